otter_pipe_hazard_unit: RTL and testbench

OTTER_PIPE_HAZARD_UNIT -- requirements
Module: otter_pipe_hazard_unit

---
 rtl/otter_pipe_hazard_unit.sv | 166 ++++++++++++++++
 tb/tb_otter_pipe_hazard_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/otter_pipe_hazard_unit.sv
// Pipeline hazard unit: tracks in-flight register writers, selects forwarding sources,
// detects load-use stalls and sequences redirect flushes. Optional counters: OTTER_HZD_PERF_EN.
module otter_pipe_hazard_unit #(
    parameter int DEPTH       = 3,
    parameter int LOAD_STAGE  = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        DE_VALID,
    input  logic [4:0]  DE_RS1_ADDR,
    input  logic [4:0]  DE_RS2_ADDR,
    input  logic        DE_RS1_USED,
    input  logic        DE_RS2_USED,
    input  logic [4:0]  DE_RD_ADDR,
    input  logic        DE_RD_USED,
    input  logic        DE_IS_LOAD,
    input  logic        REDIRECT,
    output logic        STALL,
    output logic        FLUSH,
    output logic        ISSUE,
    output logic [2:0]  FWD_A_SEL,
    output logic [2:0]  FWD_B_SEL,
    output logic [2:0]  INFLIGHT,
    output logic [31:0] STALL_COUNT,
    output logic [31:0] FLUSH_COUNT
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

    logic [DEPTH-1:0]      sb_valid_q, sb_valid_d;
    logic [DEPTH-1:0][4:0] sb_rd_q, sb_rd_d;
    logic [DEPTH-1:0]      sb_load_q, sb_load_d;
    logic [2:0]            flush_cnt_q, flush_cnt_d;
    logic [2:0]            inflight_q, inflight_d;

    logic [3:0] look_a_s, look_b_s;
    logic       hazard_s, flush_s, stall_s, issue_s;
    logic [2:0] sel_a_s, sel_b_s;

    // Returns {blocked, stage}; scanning oldest to youngest lets the youngest writer win.
    function automatic logic [3:0] src_lookup(
        input logic [4:0]            addr,
        input logic                  used,
        input logic [DEPTH-1:0]      vld,
        input logic [DEPTH-1:0][4:0] rd,
        input logic [DEPTH-1:0]      ld
    );
        logic       blocked;
        logic [2:0] stage;
        blocked = 1'b0;
        stage   = 3'd0;
        if (used && (addr != 5'd0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (vld[k] && (rd[k] == addr)) begin
                    stage   = 3'(k + 1);
                    blocked = ld[k] && ((k + 1) < LOAD_STAGE);
                end
            end
        end
        return {blocked, stage};
    endfunction

    function automatic logic [2:0] popcount(input logic [DEPTH-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Source matching, stall/flush arbitration and issue decision.
    always_comb begin
        // An empty decode slot reads nothing, so it never creates a hazard.
        look_a_s = src_lookup(DE_RS1_ADDR, DE_RS1_USED & DE_VALID, sb_valid_q, sb_rd_q, sb_load_q);
        look_b_s = src_lookup(DE_RS2_ADDR, DE_RS2_USED & DE_VALID, sb_valid_q, sb_rd_q, sb_load_q);
        hazard_s = look_a_s[3] | look_b_s[3];
        flush_s  = REDIRECT | (flush_cnt_q != 3'd0);
        stall_s  = hazard_s & ~flush_s;
        issue_s  = DE_VALID & ~stall_s & ~flush_s;
        sel_a_s  = look_a_s[3] ? 3'd0 : look_a_s[2:0];
        sel_b_s  = look_b_s[3] ? 3'd0 : look_b_s[2:0];
    end

    // Flush bubble counter: reload on redirect, otherwise drain to zero.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (REDIRECT) begin
            flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q != 3'd0) begin
            flush_cnt_d = flush_cnt_q - 3'd1;
        end else begin
            flush_cnt_d = 3'd0;
        end
    end

    // Scoreboard shift: stage 1 takes the issuing instruction or a bubble.
    always_comb begin
        sb_valid_d = {sb_valid_q[DEPTH-2:0], issue_s & DE_RD_USED & (DE_RD_ADDR != 5'd0)};
        sb_rd_d    = {sb_rd_q[DEPTH-2:0], (issue_s ? DE_RD_ADDR : 5'd0)};
        sb_load_d  = {sb_load_q[DEPTH-2:0], issue_s & DE_IS_LOAD};
        inflight_d = popcount(sb_valid_d);
    end

    // Scoreboard, flush counter and occupancy state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sb_valid_q  <= '0;
            sb_rd_q     <= '0;
            sb_load_q   <= '0;
            flush_cnt_q <= 3'd0;
            inflight_q  <= 3'd0;
        end else begin
            sb_valid_q  <= sb_valid_d;
            sb_rd_q     <= sb_rd_d;
            sb_load_q   <= sb_load_d;
            flush_cnt_q <= flush_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

`ifdef OTTER_HZD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters.
    always_comb begin
        if (stall_s && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
        if (flush_s && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Counter state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign STALL_COUNT = stall_count_q;
    assign FLUSH_COUNT = flush_count_q;
`else
    assign STALL_COUNT = 32'd0;
    assign FLUSH_COUNT = 32'd0;
`endif

    assign STALL     = stall_s;
    assign FLUSH     = flush_s;
    assign ISSUE     = issue_s;
    assign FWD_A_SEL = sel_a_s;
    assign FWD_B_SEL = sel_b_s;
    assign INFLIGHT  = inflight_q;

endmodule

// File: tb/tb_otter_pipe_hazard_unit.sv
// Directed self-checking bench for otter_pipe_hazard_unit (default parameters).
module tb_otter_pipe_hazard_unit;

`ifdef OTTER_HZD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET, DE_VALID, DE_RS1_USED, DE_RS2_USED, DE_RD_USED, DE_IS_LOAD, REDIRECT;
    logic [4:0]  DE_RS1_ADDR, DE_RS2_ADDR, DE_RD_ADDR;
    logic        STALL, FLUSH, ISSUE;
    logic [2:0]  FWD_A_SEL, FWD_B_SEL, INFLIGHT;
    logic [31:0] STALL_COUNT, FLUSH_COUNT;

    int n_cmp = 0;
    int n_bad = 0;

    otter_pipe_hazard_unit dut (
        .CLK(CLK), .RESET(RESET), .DE_VALID(DE_VALID),
        .DE_RS1_ADDR(DE_RS1_ADDR), .DE_RS2_ADDR(DE_RS2_ADDR),
        .DE_RS1_USED(DE_RS1_USED), .DE_RS2_USED(DE_RS2_USED),
        .DE_RD_ADDR(DE_RD_ADDR), .DE_RD_USED(DE_RD_USED), .DE_IS_LOAD(DE_IS_LOAD),
        .REDIRECT(REDIRECT), .STALL(STALL), .FLUSH(FLUSH), .ISSUE(ISSUE),
        .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL), .INFLIGHT(INFLIGHT),
        .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_de(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rdu, input logic ld);
        DE_VALID = v; DE_RS1_ADDR = rs1; DE_RS1_USED = u1; DE_RS2_ADDR = rs2;
        DE_RS2_USED = u2; DE_RD_ADDR = rd; DE_RD_USED = rdu; DE_IS_LOAD = ld;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b0; REDIRECT = 1'b0;
        set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick; tick;
        RESET = 1'b1;
    endtask

    task automatic test_reset;
        logic [8:0] st, ex;
        RESET = 1'b0; REDIRECT = 1'b1;
        set_de(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
        tick; tick;
        RESET = 1'b1; REDIRECT = 1'b0;
        set_de(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd0, 3'd0};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL reset_status: got %b required %b", st, ex); end
        n_cmp++; if (INFLIGHT !== 3'd0) begin n_bad++; $display("FAIL reset_inflight: got %0d required 0", INFLIGHT); end
        n_cmp++; if ({STALL_COUNT, FLUSH_COUNT} !== 64'd0) begin n_bad++; $display("FAIL reset_counters: got %0d/%0d required 0/0", STALL_COUNT, FLUSH_COUNT); end
        tick;
    endtask

    task automatic test_alu_forward;
        logic [8:0] st, ex;
        do_reset;
        set_de(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd0, 3'd0};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL alu_c0: got %b required %b", st, ex); end
        tick;
        set_de(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0); #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd1, 3'd1};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL alu_back_to_back: got %b required %b", st, ex); end
        n_cmp++; if (INFLIGHT !== 3'd1) begin n_bad++; $display("FAIL alu_inflight1: got %0d required 1", INFLIGHT); end
        tick;
        set_de(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd11, 1'b1, 1'b0); #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd1, 3'd2};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL alu_stage2: got %b required %b", st, ex); end
        n_cmp++; if (INFLIGHT !== 3'd2) begin n_bad++; $display("FAIL alu_inflight2: got %0d required 2", INFLIGHT); end
        tick;
        set_de(1'b1, 5'd5, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0); #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd3, 3'd1};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL alu_stage3: got %b required %b", st, ex); end
        n_cmp++; if (INFLIGHT !== 3'd3) begin n_bad++; $display("FAIL alu_inflight3: got %0d required 3", INFLIGHT); end
        tick;
        set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        n_cmp++; if (ISSUE !== 1'b0) begin n_bad++; $display("FAIL alu_idle_issue: got %b required 0", ISSUE); end
        tick;
        n_cmp++; if (INFLIGHT !== 3'd2) begin n_bad++; $display("FAIL alu_drain: got %0d required 2", INFLIGHT); end
    endtask

    task automatic test_load_use;
        logic [8:0] st, ex;
        logic [2:0] s3, e3;
        do_reset;
        set_de(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); tick;
        set_de(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0); #1;
        s3 = {STALL, FLUSH, ISSUE}; e3 = 3'b100;
        n_cmp++; if (s3 !== e3) begin n_bad++; $display("FAIL lu_stall: got %b required %b", s3, e3); end
        tick;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd2, 3'd0};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL lu_release: got %b required %b", st, ex); end
        n_cmp++; if (STALL_COUNT !== (PERF ? 32'd1 : 32'd0)) begin n_bad++; $display("FAIL lu_stall_count: got %0d required %0d", STALL_COUNT, PERF ? 1 : 0); end
        tick;
        set_de(1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd13, 1'b1, 1'b0); #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd1, 3'd3};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL lu_followup: got %b required %b", st, ex); end
        n_cmp++; if (INFLIGHT !== 3'd2) begin n_bad++; $display("FAIL lu_inflight: got %0d required 2", INFLIGHT); end
        tick;
    endtask

    task automatic test_youngest;
        logic [8:0] st, ex;
        logic [2:0] s3, e3;
        do_reset;
        set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); tick;
        set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); tick;
        set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); tick;
        set_de(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd14, 1'b1, 1'b0); #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd1, 3'd1};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL youngest_wins: got %b required %b", st, ex); end
        n_cmp++; if (INFLIGHT !== 3'd3) begin n_bad++; $display("FAIL youngest_inflight: got %0d required 3", INFLIGHT); end
        // a younger load shadows an older ALU writer of the same register
        do_reset;
        set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); tick;
        set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1); tick;
        set_de(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0); #1;
        s3 = {STALL, FLUSH, ISSUE}; e3 = 3'b100;
        n_cmp++; if (s3 !== e3) begin n_bad++; $display("FAIL shadow_stall: got %b required %b", s3, e3); end
        tick;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd2, 3'd0};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL shadow_release: got %b required %b", st, ex); end
        tick;
    endtask

    task automatic test_redirect_stall;
        logic [8:0] st, ex;
        logic [2:0] s3;
        do_reset;
        set_de(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); tick;
        set_de(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        REDIRECT = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            s3 = {STALL, FLUSH, ISSUE};
            n_cmp++; if (s3 !== 3'b010) begin n_bad++; $display("FAIL redir_flush_c%0d: got %b required 010", c, s3); end
            tick;
            REDIRECT = 1'b0;
        end
        #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd0, 3'd0};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL redir_after: got %b required %b", st, ex); end
        n_cmp++; if (FLUSH_COUNT !== (PERF ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL redir_flush_count: got %0d required %0d", FLUSH_COUNT, PERF ? 3 : 0); end
        n_cmp++; if (STALL_COUNT !== 32'd0) begin n_bad++; $display("FAIL redir_stall_count: got %0d required 0", STALL_COUNT); end
        tick;
    endtask

    task automatic test_redirect_reload;
        logic [5:0] redir_tbl;
        logic [5:0] flush_tbl;
        logic [2:0] s3, e3;
        redir_tbl = 6'b000101;
        flush_tbl = 6'b011111;
        do_reset;
        for (int c = 0; c < 6; c++) begin
            REDIRECT = redir_tbl[c];
            #1;
            s3 = {STALL, FLUSH, ISSUE}; e3 = {1'b0, flush_tbl[c], ~flush_tbl[c]};
            n_cmp++; if (s3 !== e3) begin n_bad++; $display("FAIL reload_c%0d: got %b required %b", c, s3, e3); end
            tick;
        end
        REDIRECT = 1'b0;
    endtask

    task automatic test_x0;
        logic [8:0] st, ex;
        do_reset;
        set_de(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1); #1;
        n_cmp++; if (ISSUE !== 1'b1) begin n_bad++; $display("FAIL x0_issue: got %b required 1", ISSUE); end
        tick;
        set_de(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0); #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd0, 3'd0};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL x0_read: got %b required %b", st, ex); end
        n_cmp++; if (INFLIGHT !== 3'd0) begin n_bad++; $display("FAIL x0_inflight: got %0d required 0", INFLIGHT); end
        tick;
        set_de(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd0, 3'd0};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL rd_unused_read: got %b required %b", st, ex); end
        tick;
        n_cmp++; if (INFLIGHT !== 3'd1) begin n_bad++; $display("FAIL x0_inflight_after: got %0d required 1", INFLIGHT); end
    endtask

    task automatic test_reset_mid_stall;
        logic [8:0] st, ex;
        do_reset;
        REDIRECT = 1'b1; tick;
        REDIRECT = 1'b0; tick; tick;
        n_cmp++; if (FLUSH_COUNT !== (PERF ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL rms_flush_count: got %0d required %0d", FLUSH_COUNT, PERF ? 3 : 0); end
        set_de(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); tick;
        set_de(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0); #1;
        n_cmp++; if (STALL !== 1'b1) begin n_bad++; $display("FAIL rms_stall: got %b required 1", STALL); end
        RESET = 1'b0; tick;
        RESET = 1'b1; #1;
        st = {STALL, FLUSH, ISSUE, FWD_A_SEL, FWD_B_SEL}; ex = {1'b0, 1'b0, 1'b1, 3'd0, 3'd0};
        n_cmp++; if (st !== ex) begin n_bad++; $display("FAIL rms_after: got %b required %b", st, ex); end
        n_cmp++; if (INFLIGHT !== 3'd0) begin n_bad++; $display("FAIL rms_inflight: got %0d required 0", INFLIGHT); end
        n_cmp++; if ({STALL_COUNT, FLUSH_COUNT} !== 64'd0) begin n_bad++; $display("FAIL rms_counters: got %0d/%0d required 0/0", STALL_COUNT, FLUSH_COUNT); end
        // reset on the same edge as a redirect cancels the flush
        REDIRECT = 1'b1; RESET = 1'b0; tick;
        REDIRECT = 1'b0; RESET = 1'b1; #1;
        n_cmp++; if ({FLUSH, ISSUE} !== 2'b01) begin n_bad++; $display("FAIL rms_redirect_override: got %b required 01", {FLUSH, ISSUE}); end
        tick;
    endtask

    initial begin
        RESET = 1'b0; REDIRECT = 1'b0;
        set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        test_reset;
        test_alu_forward;
        test_load_use;
        test_youngest;
        test_redirect_stall;
        test_redirect_reload;
        test_x0;
        test_reset_mid_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
